// File: rtl/pio_debounced_capture_if.sv
// Avalon-MM slave bus for pio_debounced_capture.
//   address   [1:0]  word address
//   read             read strobe (readdata valid one cycle later)
//   write            write strobe (zero wait states)
//   writedata [31:0] write data
//   readdata  [31:0] registered read data
interface pio_debounced_capture_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/pio_debounced_capture.sv
// Debounced input PIO with per-channel edge capture and masked interrupt.
//   clk, reset  single clock, synchronous active-high reset
//   in_port     WIDTH asynchronous raw inputs
//   bus         Avalon-MM slave: 0 DATA (RO), 1 reserved, 2 IRQ_MASK (RW),
//               3 EDGE_CAP (W1C); readLatency 1
//   irq         level interrupt, |(EDGE_CAP & IRQ_MASK)

// One channel: synchroniser chain followed by a stable-count debouncer.
module pio_dbc_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  output logic deb
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   deb_q, deb_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_raw};
    cnt_d  = '0;
    deb_d  = deb_q;
    // Any cycle where the synced level agrees with deb restarts the count,
    // so only DEBOUNCE_CYCLES consecutive disagreeing cycles flip deb.
    if (sync_q[SYNC_STAGES-1] != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync_q[SYNC_STAGES-1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb = deb_q;
endmodule

module pio_debounced_capture #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        in_port,
  pio_debounced_capture_if.slave  bus,
  output logic                    irq
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_dly_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] evt, clr;
  logic [31:0]      rdata_q, rdata_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pio_dbc_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .in_raw(in_port[i]),
      .deb   (deb[i])
    );
  end

  always_comb begin
    case (EDGE_MODE)
      1:       evt = ~deb & deb_dly_q;
      2:       evt = deb ^ deb_dly_q;
      default: evt = deb & ~deb_dly_q;
    endcase

    clr = '0;
    if (bus.write && bus.address == 2'd3) clr = bus.writedata[WIDTH-1:0];
    // OR-ing the event after the clear makes a same-cycle set win.
    cap_d = (cap_q & ~clr) | evt;

    mask_d = mask_q;
    if (bus.write && bus.address == 2'd2) mask_d = bus.writedata[WIDTH-1:0];

    // Muxes the current (pre-write) register values, so a read colliding
    // with a write to the same register returns the old contents.
    rdata_d = rdata_q;
    if (bus.read) begin
      rdata_d = '0;
      case (bus.address)
        2'd0:    rdata_d[WIDTH-1:0] = deb;
        2'd2:    rdata_d[WIDTH-1:0] = mask_q;
        2'd3:    rdata_d[WIDTH-1:0] = cap_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_dly_q <= '0;
      mask_q    <= '0;
      cap_q     <= '0;
      rdata_q   <= '0;
    end else begin
      deb_dly_q <= deb;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  // Registers only: no combinational path from the bus into irq.
  assign irq = |(cap_q & mask_q);
endmodule

// File: tb/tb_pio_debounced_capture.sv
module tb_pio_debounced_capture;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] inp   = '0;
  logic [1:0]   addr  = '0;
  logic         rd    = 1'b0;
  logic         wr    = 1'b0;
  logic [31:0]  wdata = '0;

  pio_debounced_capture_if b0 ();
  pio_debounced_capture_if b1 ();
  pio_debounced_capture_if b2 ();
  assign b0.address = addr; assign b0.read = rd; assign b0.write = wr; assign b0.writedata = wdata;
  assign b1.address = addr; assign b1.read = rd; assign b1.write = wr; assign b1.writedata = wdata;
  assign b2.address = addr; assign b2.read = rd; assign b2.write = wr; assign b2.writedata = wdata;

  logic irq0, irq1, irq2;
  logic [31:0] rdat [3];
  logic        irqv [3];
  assign rdat[0] = b0.readdata; assign rdat[1] = b1.readdata; assign rdat[2] = b2.readdata;
  assign irqv[0] = irq0; assign irqv[1] = irq1; assign irqv[2] = irq2;

  pio_debounced_capture #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0))
    u_rise (.clk(clk), .reset(rst), .in_port(inp), .bus(b0.slave), .irq(irq0));
  pio_debounced_capture #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(1))
    u_fall (.clk(clk), .reset(rst), .in_port(inp), .bus(b1.slave), .irq(irq1));
  pio_debounced_capture #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(2))
    u_any  (.clk(clk), .reset(rst), .in_port(inp), .bus(b2.slave), .irq(irq2));

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model. History of raw samples; a channel's debounced level
  // becomes v once the synchronised input has shown v for the last DC
  // consecutive cycles while the level was !v.
  logic [W-1:0] samp [SS+DC-1];
  logic [W-1:0] mdeb, mdebd;
  logic [W-1:0] mcap [3];
  logic [W-1:0] mmask [3];
  logic [31:0]  mrd [3];

  always @(posedge clk) begin : model
    logic [W-1:0] nd, ev;
    logic all1, all0;
    if (rst) begin
      for (int j = 0; j < SS+DC-1; j++) samp[j] <= '0;
      mdeb  <= '0;
      mdebd <= '0;
      for (int k = 0; k < 3; k++) begin
        mcap[k] <= '0; mmask[k] <= '0; mrd[k] <= '0;
      end
    end else begin
      nd = mdeb;
      for (int i = 0; i < W; i++) begin
        all1 = 1'b1; all0 = 1'b1;
        for (int m = 0; m < DC; m++) begin
          if (samp[SS-1+m][i]) all0 = 1'b0; else all1 = 1'b0;
        end
        if (!mdeb[i] && all1) nd[i] = 1'b1;
        if (mdeb[i] && all0)  nd[i] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        if (k == 0)      ev = mdeb & ~mdebd;
        else if (k == 1) ev = ~mdeb & mdebd;
        else             ev = mdeb ^ mdebd;
        if (rd) begin
          if (addr == 2'd0)      mrd[k] <= 32'(mdeb);
          else if (addr == 2'd2) mrd[k] <= 32'(mmask[k]);
          else if (addr == 2'd3) mrd[k] <= 32'(mcap[k]);
          else                   mrd[k] <= '0;
        end
        if (wr && addr == 2'd3) mcap[k] <= (mcap[k] & ~wdata[W-1:0]) | ev;
        else                    mcap[k] <= mcap[k] | ev;
        if (wr && addr == 2'd2) mmask[k] <= wdata[W-1:0];
      end
      mdebd <= mdeb;
      mdeb  <= nd;
      for (int j = SS+DC-2; j > 0; j--) samp[j] <= samp[j-1];
      samp[0] <= inp;
    end
  end

  // Every-cycle comparison against the model (outputs only move on posedge).
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_rdata_m%0d", k), rdat[k], mrd[k]);
      chk($sformatf("model_irq_m%0d", k), 32'(irqv[k]), 32'(|(mcap[k] & mmask[k])));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd1(input int k, input logic [1:0] a, input logic [31:0] exp, input string nm);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0;
    chk(nm, rdat[k], exp);
  endtask

  task automatic wr1(input logic [1:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  initial begin
    // Reset values
    tick(2);
    rst = 1'b0;
    rd1(0, 2'd0, 32'h0, "rst_data");
    rd1(0, 2'd1, 32'h0, "rst_rsvd");
    rd1(0, 2'd2, 32'h0, "rst_mask");
    rd1(0, 2'd3, 32'h0, "rst_cap");
    chk("rst_irq", 32'(irq0), 32'h0);

    // Clean rise: sampled on E1, DATA changes on E6, EDGE_CAP on E7
    inp = 8'h05;
    tick(5);
    rd1(0, 2'd0, 32'h00, "rise_data_pre");
    rd1(0, 2'd0, 32'h05, "rise_data_e7");
    rd1(0, 2'd3, 32'h05, "rise_cap");
    chk("rise_irq_unmasked", 32'(irq0), 32'h0);
    wr1(2'd2, 32'h04);
    chk("rise_irq_masked", 32'(irq0), 32'h1);

    // Glitch of 3 cycles rejected
    inp = 8'h07; tick(3); inp = 8'h05; tick(10);
    rd1(0, 2'd0, 32'h05, "glitch_data");
    rd1(0, 2'd3, 32'h05, "glitch_cap");
    chk("glitch_irq", 32'(irq0), 32'h1);
    // 4-cycle pulse accepted, then released 4 cycles later
    inp = 8'h07; tick(4); inp = 8'h05; tick(2);
    rd1(0, 2'd0, 32'h07, "pulse_data_high");
    tick(8);
    rd1(0, 2'd0, 32'h05, "pulse_data_back");
    rd1(0, 2'd3, 32'h07, "pulse_cap");

    // W1C
    wr1(2'd3, 32'h02);
    wr1(2'd3, 32'h01);
    rd1(0, 2'd3, 32'h04, "w1c_cap");
    // Set vs clear race on bit 2
    inp = 8'h01; tick(12);
    wr1(2'd3, 32'hFF);
    rd1(0, 2'd3, 32'h00, "race_cap_cleared");
    chk("race_irq_low", 32'(irq0), 32'h0);
    inp = 8'h05; tick(6);
    wr1(2'd3, 32'h04);
    rd1(0, 2'd3, 32'h04, "race_set_wins");
    chk("race_irq", 32'(irq0), 32'h1);

    // Falling / any edge modes on bit 7
    wr1(2'd3, 32'hFF);
    inp = 8'h85; tick(10);
    rd1(2, 2'd3, 32'h80, "any_rise");
    rd1(1, 2'd3, 32'h00, "fall_rise_ignored");
    inp = 8'h05; tick(10);
    rd1(2, 2'd3, 32'h80, "any_fall");
    rd1(1, 2'd3, 32'h80, "fall_fall");
    rd1(0, 2'd3, 32'h80, "rise_mode_b7");

    // Reset mid-debounce
    inp = 8'h04; tick(10);
    inp = 8'h05; tick(4);
    rst = 1'b1; tick(2); rst = 1'b0;
    rd1(0, 2'd2, 32'h00, "midrst_mask");
    tick(4);
    rd1(0, 2'd0, 32'h00, "midrst_data_pre");
    rd1(0, 2'd0, 32'h05, "midrst_data_r7");
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
